// File: rtl/bcd_step_counter_pkg.sv
// Shared types, constants and step arithmetic for the BCD step counter.
// Used by the top level and the tick prescaler.
package bcd_step_pkg;

   localparam int unsigned CODE_W = 4;

   localparam logic [CODE_W-1:0] DEF_MIN_CODE = 4'd1;
   localparam logic [CODE_W-1:0] DEF_MAX_CODE = 4'd9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Returns {wrap, next}; wrap is set when the step crosses a range end.
   function automatic logic [CODE_W:0] next_code(
      input logic [CODE_W-1:0] code,
      input logic              up,
      input logic [CODE_W-1:0] min_code,
      input logic [CODE_W-1:0] max_code
   );
      logic [CODE_W:0] res;
      if (up) begin
         if (code == max_code) res = {1'b1, min_code};
         else                  res = {1'b0, code + 1'b1};
      end else begin
         if (code == min_code) res = {1'b1, max_code};
         else                  res = {1'b0, code - 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_step_counter_if.sv
// Control and code-output bundle between the counter and its user.
// master drives the controls; slave is the counter itself.
interface bcd_step_counter_if;
   import bcd_step_pkg::*;

   logic              en;
   logic              dir;
   logic              step;
   logic              load;
   logic [CODE_W-1:0] load_val;
   logic              a;
   logic              b;
   logic              c;
   logic              d;
   logic              wrap;
   logic              load_err;
   logic              running;

   modport master (
      output en, dir, step, load, load_val,
      input  a, b, c, d, wrap, load_err, running
   );

   modport slave (
      input  en, dir, step, load, load_val,
      output a, b, c, d, wrap, load_err, running
   );

endinterface

// File: rtl/bcd_step_counter_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled
// cycles; clr restarts the count so the next tick is a full period away.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_comb begin
      tick = en && (cnt == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (tick) cnt <= '0;
         else      cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_step_counter.sv
// Registered 0001..1001 code generator driving a BCD one-hot decoder.
// Define BCD_STEP_PINGPONG_EN to bounce direction at the range ends in RUN.
module bcd_step_counter
   import bcd_step_pkg::*;
#(
   parameter int unsigned       TICK_DIV = 4,
   parameter logic [CODE_W-1:0] MIN_CODE = DEF_MIN_CODE,
   parameter logic [CODE_W-1:0] MAX_CODE = DEF_MAX_CODE
) (
   input logic               clk,
   input logic               rst,
   bcd_step_counter_if.slave bus
);

   if (TICK_DIV < 1 || MIN_CODE >= MAX_CODE) begin : g_bad_params
      $error("bcd_step_counter: illegal TICK_DIV/MIN_CODE/MAX_CODE");
   end

   state_t            state;
   logic              step_q;
   logic [CODE_W-1:0] code;
   logic              wrap_q;
   logic              load_err_q;

   logic              step_edge;
   logic              run_st;
   logic              run_entry;
   logic              load_ok;
   logic              tick;
   logic              step_req;
   logic              step_up;
   logic              step_wrap;
   logic [CODE_W-1:0] step_code;

`ifdef BCD_STEP_PINGPONG_EN
   logic              dir_q;
`endif

   always_comb begin
      step_edge = bus.step & ~step_q;
      run_st    = (state == RUN);
      run_entry = (state == IDLE) && bus.en;
      load_ok   = bus.load && (bus.load_val >= MIN_CODE) && (bus.load_val <= MAX_CODE);
      step_req  = run_st ? tick : step_edge;

      step_up = bus.dir;
      {step_wrap, step_code} = next_code(code, bus.dir, MIN_CODE, MAX_CODE);
`ifdef BCD_STEP_PINGPONG_EN
      // In RUN a would-be wrap becomes a reversal: step once the other way.
      if (run_st) begin
         step_up = dir_q;
         {step_wrap, step_code} = next_code(code, dir_q, MIN_CODE, MAX_CODE);
         if (step_wrap) begin
            step_up = ~dir_q;
            {step_wrap, step_code} = next_code(code, ~dir_q, MIN_CODE, MAX_CODE);
         end
      end
`endif
   end

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (run_entry | load_ok),
      .en   (run_st),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         step_q     <= 1'b0;
         code       <= MIN_CODE;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
`ifdef BCD_STEP_PINGPONG_EN
         dir_q      <= 1'b1;
`endif
      end else begin
         step_q     <= bus.step;
         state      <= bus.en ? RUN : IDLE;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (load_ok) begin
            code <= bus.load_val;
         end else begin
            // A rejected load still lets a coincident step through.
            load_err_q <= bus.load;
            if (step_req) begin
               code   <= step_code;
               wrap_q <= step_wrap;
`ifdef BCD_STEP_PINGPONG_EN
               if (run_st) dir_q <= step_up;
`endif
            end
         end
`ifdef BCD_STEP_PINGPONG_EN
         if (run_entry) dir_q <= bus.dir;
`endif
      end
   end

   assign bus.a        = code[3];
   assign bus.b        = code[2];
   assign bus.c        = code[1];
   assign bus.d        = code[0];
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;
   assign bus.running  = run_st;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter: vector table, hand sequences for
// multi-cycle corners, and a randomized run against a behavioural model.
module tb_bcd_step_counter;

   localparam int TD   = 4;
   localparam int MINC = 1;
   localparam int MAXC = 9;
   localparam int NC   = MAXC - MINC + 1;
`ifdef BCD_STEP_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_step_counter_if bus ();

   bcd_step_counter #(
      .TICK_DIV(TD),
      .MIN_CODE(4'(MINC)),
      .MAX_CODE(4'(MAXC))
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state.
   int m_code, m_since;
   bit m_run, m_sq, m_wrap, m_lerr, m_pdir;

   task automatic model_step(input bit r, e, dr, s, l, input int lv);
      bit edge_s, tick, up;
      if (r) begin
         m_code = MINC; m_run = 0; m_sq = 0; m_wrap = 0; m_lerr = 0;
         m_pdir = 1; m_since = 0;
         return;
      end
      edge_s = s && !m_sq;
      m_sq   = s;
      tick   = m_run && ((m_since % TD) == TD - 1);
      m_wrap = 0;
      m_lerr = 0;
      if (l && lv >= MINC && lv <= MAXC) begin
         m_code  = lv;
         m_since = 0;
      end else begin
         m_lerr = l;
         if (m_run ? tick : edge_s) begin
            up = dr;
            if (PP && m_run) up = m_pdir;
            if (PP && m_run && ((up && m_code == MAXC) || (!up && m_code == MINC))) begin
               m_pdir = !up;
               m_code = up ? m_code - 1 : m_code + 1;
            end else begin
               m_wrap = up ? (m_code == MAXC) : (m_code == MINC);
               m_code = up ? MINC + ((m_code - MINC + 1) % NC)
                           : MINC + ((m_code - MINC + NC - 1) % NC);
            end
         end
         if (m_run) m_since++;
      end
      if (!m_run && e) begin
         m_since = 0;
         m_pdir  = dr;
      end
      m_run = e;
   endtask

   task automatic apply(input bit r, e, dr, s, l, input int lv);
      rst          = r;
      bus.en       = e;
      bus.dir      = dr;
      bus.step     = s;
      bus.load     = l;
      bus.load_val = 4'(lv);
      @(posedge clk);
      #1;
      model_step(r, e, dr, s, l, lv);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int code, input int w, input int le, input int rn);
      chk({tag, ".code"}, int'({bus.a, bus.b, bus.c, bus.d}), code);
      chk({tag, ".wrap"}, int'(bus.wrap), w);
      chk({tag, ".load_err"}, int'(bus.load_err), le);
      chk({tag, ".running"}, int'(bus.running), rn);
   endtask

   typedef struct {
      bit r, e, dr, s, l;
      int lv;
      int code, w, le, rn;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(bit r, e, dr, s, l, int lv, int code, w, le, rn);
      vec_t v;
      v.r = r; v.e = e; v.dr = dr; v.s = s; v.l = l; v.lv = lv;
      v.code = code; v.w = w; v.le = le; v.rn = rn;
      return v;
   endfunction

   initial begin
      bit ren, rdir;
      int first, second;
      rst = 1; bus.en = 0; bus.dir = 1; bus.step = 0; bus.load = 0; bus.load_val = '0;

      //               r  e  d  s  l  lv   code w le rn
      tbl[0]  = mk(1, 0, 1, 0, 0, 0,    1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 0, 0, 0,    1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 1, 0, 0,    2, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, 0, 0,    2, 0, 0, 0);
      tbl[4]  = mk(0, 0, 1, 0, 0, 0,    2, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 1, 0, 0,    3, 0, 0, 0);
      tbl[6]  = mk(0, 0, 1, 0, 1, 7,    7, 0, 0, 0);
      tbl[7]  = mk(0, 0, 1, 0, 1, 0,    7, 0, 1, 0);
      tbl[8]  = mk(0, 0, 1, 0, 1, 10,   7, 0, 1, 0);
      tbl[9]  = mk(0, 0, 1, 0, 0, 0,    7, 0, 0, 0);
      tbl[10] = mk(0, 0, 1, 1, 1, 15,   8, 0, 1, 0);
      tbl[11] = mk(0, 0, 1, 0, 0, 0,    8, 0, 0, 0);
      tbl[12] = mk(0, 0, 1, 1, 0, 0,    9, 0, 0, 0);
      tbl[13] = mk(0, 0, 1, 0, 0, 0,    9, 0, 0, 0);
      tbl[14] = mk(0, 0, 1, 1, 0, 0,    1, 1, 0, 0);
      tbl[15] = mk(0, 0, 1, 0, 0, 0,    1, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 1, 0, 0,    9, 1, 0, 0);
      tbl[17] = mk(0, 0, 0, 0, 0, 0,    9, 0, 0, 0);
      tbl[18] = mk(0, 1, 0, 0, 0, 0,    9, 0, 0, 1);
      tbl[19] = mk(0, 1, 0, 0, 0, 0,    9, 0, 0, 1);
      tbl[20] = mk(0, 1, 0, 0, 0, 0,    9, 0, 0, 1);
      tbl[21] = mk(0, 1, 0, 0, 0, 0,    9, 0, 0, 1);
      tbl[22] = mk(0, 1, 0, 0, 0, 0,    8, 0, 0, 1);
      tbl[23] = mk(0, 1, 0, 1, 0, 0,    8, 0, 0, 1);
      tbl[24] = mk(0, 1, 0, 0, 0, 0,    8, 0, 0, 1);
      tbl[25] = mk(0, 1, 0, 0, 0, 0,    8, 0, 0, 1);
      tbl[26] = mk(0, 1, 0, 0, 0, 0,    7, 0, 0, 1);
      tbl[27] = mk(0, 0, 0, 0, 0, 0,    7, 0, 0, 0);
      tbl[28] = mk(1, 1, 0, 0, 1, 5,    1, 0, 0, 0);

      for (int i = 0; i < 29; i++) begin
         apply(tbl[i].r, tbl[i].e, tbl[i].dr, tbl[i].s, tbl[i].l, tbl[i].lv);
         chk_all($sformatf("vec%0d", i), tbl[i].code, tbl[i].w, tbl[i].le, tbl[i].rn);
      end

      // Reset release with en low holds the reset state.
      apply(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         apply(0, 0, 1, 0, 0, 0);
         chk_all("idle_hold", 1, 0, 0, 0);
      end

      // Nine up pulses: 2..9 then wrap to 1.
      for (int i = 1; i <= 9; i++) begin
         apply(0, 0, 1, 1, 0, 0);
         chk_all("pulse_hi", (i == 9) ? 1 : i + 1, (i == 9) ? 1 : 0, 0, 0);
         apply(0, 0, 1, 0, 0, 0);
         chk_all("pulse_lo", (i == 9) ? 1 : i + 1, 0, 0, 0);
      end
      // A step held high for five cycles is a single step.
      for (int i = 0; i < 5; i++) begin
         apply(0, 0, 1, 1, 0, 0);
         chk_all("step_held", 2, 0, 0, 0);
      end
      apply(0, 0, 1, 0, 0, 0);

      // RUN, down from 1: first step TICK_DIV cycles after entering.
      first  = PP ? 2 : 9;
      second = PP ? 3 : 8;
      apply(1, 0, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0);
      chk_all("run_enter", 1, 0, 0, 1);
      for (int i = 0; i < TD - 1; i++) begin
         apply(0, 1, 0, 0, 0, 0);
         chk_all("run_wait1", 1, 0, 0, 1);
      end
      apply(0, 1, 0, 0, 0, 0);
      chk_all("run_tick1", first, PP ? 0 : 1, 0, 1);
      for (int i = 0; i < TD - 1; i++) begin
         apply(0, 1, 0, 0, 0, 0);
         chk_all("run_wait2", first, 0, 0, 1);
      end
      apply(0, 1, 0, 0, 0, 0);
      chk_all("run_tick2", second, 0, 0, 1);

      // Load coincident with a tick wins and restarts the prescaler.
      for (int i = 0; i < TD - 1; i++) begin
         apply(0, 1, 0, 0, 0, 0);
         chk_all("ld_wait", second, 0, 0, 1);
      end
      apply(0, 1, 0, 0, 1, 5);
      chk_all("ld_on_tick", 5, 0, 0, 1);
      for (int i = 0; i < TD - 1; i++) begin
         apply(0, 1, 0, 0, 0, 0);
         chk_all("ld_after", 5, 0, 0, 1);
      end
      apply(0, 1, 0, 0, 0, 0);
      chk_all("ld_next_tick", PP ? 6 : 4, 0, 0, 1);

      // Reset mid-RUN at code 6.
      apply(0, 1, 0, 0, 1, 6);
      chk_all("pre_rst", 6, 0, 0, 1);
      apply(1, 1, 0, 0, 0, 0);
      chk_all("mid_rst", 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0);
      chk_all("rerun", 1, 0, 0, 1);
      for (int i = 0; i < TD - 1; i++) begin
         apply(0, 1, 0, 0, 0, 0);
         chk_all("rerun_wait", 1, 0, 0, 1);
      end
      apply(0, 1, 0, 0, 0, 0);
      chk_all("rerun_tick", PP ? 2 : 9, PP ? 0 : 1, 0, 1);

`ifdef BCD_STEP_PINGPONG_EN
      // Ping-pong up from 8: 9, 8, 7 with no wrap pulses.
      apply(1, 0, 1, 0, 0, 0);
      apply(0, 0, 1, 0, 1, 8);
      apply(0, 1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < TD - 1; i++) begin
            apply(0, 1, 1, 0, 0, 0);
            chk_all("pp_wait", (k == 0) ? 8 : (k == 1) ? 9 : 8, 0, 0, 1);
         end
         apply(0, 1, 1, 0, 0, 0);
         chk_all("pp_step", (k == 0) ? 9 : (k == 1) ? 8 : 7, 0, 0, 1);
      end
`endif

      // Randomized traffic against the model.
      apply(1, 0, 1, 0, 0, 0);
      ren  = 0;
      rdir = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) ren = !ren;
         if ($urandom_range(7) == 0)  rdir = !rdir;
         apply($urandom_range(63) == 0, ren, rdir, 1'($urandom_range(1)),
               $urandom_range(7) == 0, int'($urandom_range(15)));
         chk_all("rand", m_code, int'(m_wrap), int'(m_lerr), int'(m_run));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_step_counter.md
Name: bcd_step_counter

Overview:
Registered 4-bit code generator sitting directly upstream of the BCD-to-decimal one-hot decoder; drives the decoder's a,b,c,d inputs (a = MSB).
- Produces codes only in the decoder's active range 0001..1001, so exactly one decoder output is always hot.
- Advances by single-step pulses (IDLE) or by a prescaled free-run tick (RUN), up or down, with wrap-around and synchronous parallel load.

Parameters:
TICK_DIV, 4, clk cycles per auto-step in RUN; legal range >= 1.
MIN_CODE, 1, lowest legal code and reset value.
MAX_CODE, 9, highest legal code; requires MIN_CODE < MAX_CODE <= 15.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  1 = RUN (auto-step), 0 = IDLE.
dir  input  1  1 = count up, 0 = count down; sampled on each step.
step  input  1  level input; its rising edge requests one step in IDLE.
load  input  1  synchronous load request, single cycle.
load_val  input  4  value to load.
a  output  1  code bit 3 (MSB).
b  output  1  code bit 2.
c  output  1  code bit 1.
d  output  1  code bit 0 (LSB).
wrap  output  1  one-cycle pulse on a wrap step.
load_err  output  1  one-cycle pulse when load_val is out of range.
running  output  1  1 while FSM is in RUN.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst; it overrides every other input in the same cycle.
- Reset values:
  - code = MIN_CODE (a,b,c,d = 0,0,0,1), wrap = 0, load_err = 0, running = 0.
  - FSM = IDLE, prescaler = 0, step history register = 0.
- All outputs are registered. An update decided at edge N is visible after edge N.
- FSM states IDLE, RUN:
  - IDLE -> RUN when en = 1. RUN -> IDLE when en = 0. Transitions take effect at the next edge.
  - running = (state == RUN).
- Prescaler:
  - Cleared on IDLE->RUN and on any accepted load. Counts 0..TICK_DIV-1 in RUN only.
  - tick = (prescaler == TICK_DIV-1), then the prescaler returns to 0.
  - The first auto-step occurs TICK_DIV cycles after entering RUN. TICK_DIV = 1 steps every cycle.
- Step edge:
  - step_edge = step & ~step_q. step_q is updated every cycle in both states.
  - step_edge is honoured only in IDLE and ignored in RUN. A held-high step yields exactly one step.
- Step arithmetic:
  - up: code == MAX_CODE -> MIN_CODE with wrap = 1; else code + 1.
  - down: code == MIN_CODE -> MAX_CODE with wrap = 1; else code - 1.
- Load:
  - If MIN_CODE <= load_val <= MAX_CODE: code = load_val, with no wrap.
  - Otherwise: code unchanged, load_err = 1 for one cycle.
- Priority within one cycle: rst > load > step/tick.
  - Load coincident with a tick or step_edge: load wins, the step is discarded, and the prescaler clears only if the load is accepted.
  - A rejected load does not block a coincident step.
- wrap and load_err are zero in every cycle where their condition is not met.
- Reset mid-RUN: the next cycle is IDLE with code = MIN_CODE, regardless of en. RUN re-enters on the following edge if en is still 1.
- The code never leaves [MIN_CODE, MAX_CODE].

Optional Feature:
BCD_STEP_PINGPONG_EN:
- Defined:
  - An internal direction register replaces dir during stepping. It is set to 1 at reset and loaded from dir on every IDLE->RUN transition.
  - At MAX_CODE going up, or MIN_CODE going down, the block reverses direction and steps one code the other way (9 -> 8, 1 -> 2). No wrap pulse is generated.
  - In IDLE, dir is used directly, and the block wraps as normal.
- Undefined: plain wrap-around in all states, as above.

Decomposition:
- Package bcd_step_pkg:
  - state enum {IDLE, RUN}.
  - CODE_W = 4.
  - Default MIN_CODE/MAX_CODE constants.
  - Helper function next_code(code, up, min, max) returning {wrap, code}.
- One sub-module, tick_prescaler:
  - Parameter TICK_DIV.
  - Ports clk, rst, clr, en, tick.
- Edge detection and the FSM stay in the top level.

Test Plan:
- Reset release, en = 0: abcd = 0001, running = 0, wrap = 0 for 10 cycles.
- IDLE, dir = 1, nine step pulses from 0001: codes 0010..1001, then 0001 with wrap = 1 on that single cycle. Holding step high for 5 cycles gives exactly one step.
- RUN, TICK_DIV = 4, dir = 0, start 0001: the first step lands 4 cycles after en rises, giving 1001 with wrap = 1; then 1000 four cycles later.
- load with load_val = 0111 gives 0111. load_val = 0000 or 1010 leaves the code unchanged with load_err = 1 for one cycle. A load of 0101 coincident with a tick gives 0101, and the next tick comes 4 cycles later.
- rst asserted mid-RUN at code 0110: next cycle abcd = 0001, running = 0. The first tick after re-entering RUN arrives TICK_DIV cycles later.
- With BCD_STEP_PINGPONG_EN, RUN, up from 1000: codes 1001, 1000, 0111, with no wrap pulses.
